// File: rtl/game_ctrl.sv
// Jack-Frost game sequencer: state machine, health, invulnerability timer,
// score accumulation and win/lose decision. All outputs are registered.
module game_ctrl #(
    parameter int unsigned MONSTER_NUM   = 2,
    parameter int unsigned GROUND_NUM    = 50,
    parameter int unsigned HEALTH_INIT   = 5,
    parameter int unsigned INVULN_CYCLES = 300000000,
    parameter int unsigned BLOCK_PTS     = 1,
    parameter int unsigned FREEZE_PTS    = 10,
    parameter int unsigned FLASH_BIT     = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MONSTER_NUM-1:0] hit,
    input  logic [GROUND_NUM-1:0]  touched,
    input  logic [MONSTER_NUM-1:0] frozen,
    output logic [2:0]             state,
    output logic [3:0]             health,
    output logic [31:0]            score,
    output logic                   invuln,
    output logic                   flash,
    output logic [GROUND_NUM-1:0]  iced_map,
    output logic                   game_over,
    output logic                   win
);
    // state | meaning
    // IDLE  | waiting for the first start pulse, events ignored
    // PLAY  | normal play, hits cost health
    // HURT  | invulnerable after a hit, timer counts down to 0
    // OVER  | health exhausted, terminal until start
    // WIN   | every ground block iced, terminal until start
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_HURT = 3'd2,
        S_OVER = 3'd3,
        S_WIN  = 3'd4
    } state_t;

    localparam int unsigned TW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;

    state_t                 st_q, st_d;
    logic [3:0]             health_d;
    logic [31:0]            score_d;
    logic [GROUND_NUM-1:0]  iced_d;
    logic [MONSTER_NUM-1:0] seen_q, seen_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [GROUND_NUM-1:0]  new_blk;
    logic [MONSTER_NUM-1:0] new_frz;
    logic [31:0]            cnt_blk, cnt_frz;
    logic [63:0]            sum_w;
    logic                   all_iced;
    logic                   timer_tap;

    // A flash bit beyond the timer width means the sprite blinks off for the whole window.
    generate
        if (FLASH_BIT < TW) begin : g_tap
            assign timer_tap = timer_d[FLASH_BIT];
        end else begin : g_no_tap
            assign timer_tap = 1'b1;
        end
    endgenerate

    assign state = st_q;

    always_comb begin
        st_d     = st_q;
        health_d = health;
        score_d  = score;
        iced_d   = iced_map;
        seen_d   = seen_q;
        timer_d  = timer_q;
        new_blk  = touched & ~iced_map;
        new_frz  = frozen & ~seen_q;
        all_iced = &(iced_map | touched);
        cnt_blk  = '0;
        cnt_frz  = '0;
        for (int i = 0; i < int'(GROUND_NUM); i++) cnt_blk = cnt_blk + 32'(new_blk[i]);
        for (int i = 0; i < int'(MONSTER_NUM); i++) cnt_frz = cnt_frz + 32'(new_frz[i]);
        sum_w = 64'(score) + 64'(cnt_blk) * 64'(BLOCK_PTS) + 64'(cnt_frz) * 64'(FREEZE_PTS);

        if (st_q == S_PLAY || st_q == S_HURT) begin
            score_d = (|sum_w[63:32]) ? 32'hFFFF_FFFF : sum_w[31:0];
            iced_d  = iced_map | touched;
            seen_d  = seen_q | frozen;
        end

        case (st_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (start) begin
                    st_d     = S_PLAY;
                    health_d = 4'(HEALTH_INIT);
                    score_d  = '0;
                    iced_d   = '0;
                    seen_d   = '0;
                    timer_d  = '0;
                end
            end
            S_PLAY: begin
                if (|hit && health <= 4'd1) begin
                    health_d = '0;
                    st_d     = S_OVER;
                end else if (|hit) begin
                    health_d = health - 4'd1;
                    if (all_iced) begin
                        st_d = S_WIN;
                    end else begin
                        st_d    = S_HURT;
                        timer_d = TW'(INVULN_CYCLES - 1);
                    end
                end else if (all_iced) begin
                    st_d = S_WIN;
                end
            end
            S_HURT: begin
                if (all_iced) begin
                    st_d    = S_WIN;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    st_d = S_PLAY;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= S_IDLE;
            health    <= 4'(HEALTH_INIT);
            score     <= '0;
            iced_map  <= '0;
            seen_q    <= '0;
            timer_q   <= '0;
            invuln    <= 1'b0;
            flash     <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            st_q      <= st_d;
            health    <= health_d;
            score     <= score_d;
            iced_map  <= iced_d;
            seen_q    <= seen_d;
            timer_q   <= timer_d;
            invuln    <= (st_d == S_HURT);
            flash     <= (st_d == S_HURT) & timer_tap;
            game_over <= (st_d == S_OVER);
            win       <= (st_d == S_WIN);
        end
    end
endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Central game sequencer for the Jack-Frost datapath. It sits between the per-object detectors (block-icing, monster-freeze, monster-contact) and the renderer and score/health display. It owns the game state machine, player health, the timed invulnerability window after a hit, score accumulation and the win/lose decision. All outputs are registered.

Parameters:
MONSTER_NUM, 2, number of monster detector lanes
GROUND_NUM, 50, number of ground blocks
HEALTH_INIT, 5, health loaded at game start (1..15)
INVULN_CYCLES, 300000000, clk cycles of invulnerability after a non-lethal hit (3 s at 100 MHz)
BLOCK_PTS, 1, score per newly iced block
FREEZE_PTS, 10, score per newly frozen monster
FLASH_BIT, 23, timer bit that drives sprite blink during invulnerability

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins or restarts a game
hit  in  MONSTER_NUM  monster-contact flags, level
touched  in  GROUND_NUM  block-icing flags, level
frozen  in  MONSTER_NUM  monster-frozen flags, level
state  out  3  0=IDLE 1=PLAY 2=HURT 3=OVER 4=WIN
health  out  4  current health
score  out  32  current score, saturating
invuln  out  1  high while in HURT
flash  out  1  invuln AND timer[FLASH_BIT]; renderer hides player when 1
iced_map  out  GROUND_NUM  blocks iced this game (sticky)
game_over  out  1  high in OVER
win  out  1  high in WIN

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, health=HEALTH_INIT, score=0, iced_map=0, internal frozen_seen=0, timer=0, invuln=flash=game_over=win=0. Reset overrides start and all event inputs, including mid-HURT.
- All inputs sampled at posedge; the effect is visible on the outputs the next cycle. Latency is 1 cycle.
- Game init (start in IDLE, OVER or WIN): health=HEALTH_INIT, score=0, iced_map=0, frozen_seen=0, timer=0, state=PLAY. start is ignored in PLAY and HURT.
- IDLE: hold. Events are ignored.
- PLAY:
  - If hit!=0 and health==1: health=0, state=OVER.
  - Else if hit!=0: health=health-1, timer=INVULN_CYCLES-1, state=HURT.
  - Else if (iced_map|touched) is all ones: state=WIN.
  - A lethal hit has priority over a simultaneous win. A non-lethal hit and win completion in the same cycle give health-1 and state=WIN; no HURT is entered.
- HURT:
  - hit is ignored.
  - timer decrements by 1 each cycle. When timer==0, state=PLAY on the next edge.
  - The win check is the same as in PLAY; win exits HURT immediately and sets timer=0.
- Scoring (PLAY and HURT only, every cycle):
  - new_blk = touched & ~iced_map; new_frz = frozen & ~frozen_seen.
  - score += popcount(new_blk)*BLOCK_PTS + popcount(new_frz)*FREEZE_PTS, computed in 33 bits and saturated at 32'hFFFFFFFF.
  - iced_map |= touched; frozen_seen |= frozen.
  - Each block and each monster scores at most once per game. A deasserted frozen does not re-arm its lane.
  - Scoring is applied in the same cycle as a hit or win transition, including the transition into OVER.
- OVER / WIN: terminal. score, health and iced_map are frozen. Only start (reinit) or rst leaves these states.
- Status outputs: invuln=(state==HURT); game_over=(state==OVER); win=(state==WIN); flash=invuln & timer[FLASH_BIT]. If FLASH_BIT >= the timer width, flash=invuln.
- The timer width is clog2(INVULN_CYCLES), minimum 1. INVULN_CYCLES=1 gives exactly one HURT cycle.
- health never underflows. It is never written in IDLE, OVER or WIN except by init.

Test Plan:
Bench parameters: HEALTH_INIT=3, INVULN_CYCLES=8, GROUND_NUM=4, MONSTER_NUM=2, FLASH_BIT=1.
1. Reset then start pulse -> next cycle state=1, health=3, score=0, iced_map=0. Then rst high mid-HURT -> state=0, health=3, invuln=0.
2. In PLAY, hit=2'b01 for 20 cycles -> health=2 and state=2 one cycle later. invuln stays high for exactly 8 cycles with no further decrement, then state=1. The still-asserted hit then gives health=1 and state=2 again. flash follows timer[1] during HURT.
3. health=1, hit=2'b10 -> health=0, state=3, game_over=1. Then start -> state=1, health=3, score=0.
4. touched=4'b0011 for 5 cycles, then 4'b0000, then 4'b0011 again -> score=2, iced_map=0011. frozen=2'b11 in one cycle -> score=22. Toggling frozen off and on -> score stays 22.
5. iced_map=0111, then in one cycle touched=1000 with hit=01 and health=3 -> health=2, state=4, score+1. Repeat with health=1 -> state=3, health=0.
6. Preload score=32'hFFFFFFF5 via a test hook or force, then frozen=2'b11 -> score=32'hFFFFFFFF (saturated).
